// File: rtl/booth_mac_pkg.sv
// Shared types and defaults for the Booth multiply-accumulate stage.
// Also holds the radix-4 Booth partial-product helper used by booth_32.
package booth_mac_pkg;

  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 8;
  localparam int ACC_W_DEF = 72;
  // Bits added above the 64-bit product when it is folded into the accumulator.
  localparam int EXT_W_DEF = ACC_W_DEF - 2 * DW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One radix-4 Booth digit (grp = {b[2i+1], b[2i], b[2i-1]}) applied to the multiplicand.
  function automatic logic [63:0] booth_pp(input logic [2:0] grp, input logic [31:0] a);
    logic [63:0] a64;
    a64 = {{32{a[31]}}, a};
    case (grp)
      3'b001, 3'b010: booth_pp = a64;
      3'b011:         booth_pp = a64 << 1;
      3'b100:         booth_pp = -(a64 << 1);
      3'b101, 3'b110: booth_pp = -a64;
      default:        booth_pp = '0;
    endcase
  endfunction

endpackage

// File: rtl/booth_mac_acc_if.sv
// Operand stream, job control and result handshake of the multiply-accumulate stage.
interface booth_mac_acc_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 8,
  parameter int ACC_W = 72
);
  logic                    start;
  logic [CNT_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_a;
  logic signed [DW-1:0]    in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    busy;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, busy
  );
endinterface

// File: rtl/booth_32.sv
// Combinational signed 32x32 -> 64 radix-4 Booth multiplier.
module booth_32
  import booth_mac_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [63:0] y
);

  logic [32:0] bx;
  logic [63:0] sum;

  assign bx = {b, 1'b0};

  // NOTE: every variable written in always_comb is given a value before any
  // conditional or loop touches it, so no path can leave it holding state (no latch).
  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + (booth_pp(bx[2*i +: 3], a) << (2 * i));
    end
  end

  assign y = sum;

endmodule

// File: rtl/booth_mac_acc.sv
// Job-based dot-product engine: registers each accepted operand pair into booth_32
// and accumulates the sign-extended products, returning the sum over a handshake.
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_mac_acc_if.slave bus
);

  localparam int EXT_W = ACC_W - 2 * DW;

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        remaining;
  logic signed [DW-1:0]    op_a;
  logic signed [DW-1:0]    op_b;
  logic                    op_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  prod;
  logic                    beat;
  logic                    start_job;

  assign beat      = bus.in_valid & bus.in_ready;
  assign start_job = (state == IDLE) & bus.start;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.start) state_nx = (bus.len != '0) ? ACC : DONE;
      ACC:   if (beat && remaining == CNT_W'(1)) state_nx = DRAIN;
      DRAIN: state_nx = DONE;  // the final pair is always pending here
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ACC);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // NOTE: the operand and accumulator registers are plain flops, not a memory,
  // so they are all cleared on reset and an aborted job leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_vld    <= 1'b0;
      acc       <= '0;
    end else begin
      if (start_job)  remaining <= bus.len;
      else if (beat)  remaining <= remaining - CNT_W'(1);

      if (beat) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
      end
      op_vld <= beat;

      if (start_job)   acc <= '0;
      else if (op_vld) acc <= acc + {{EXT_W{prod[2*DW-1]}}, prod};
    end
  end

  booth_32 u_booth (
    .a (op_a),
    .b (op_b),
    .y (prod)
  );

  assign bus.out_acc = acc;

endmodule
